// File: rtl/addsub_accumulator.sv
// ============================================================================
// addsub_accumulator: LOAD/ADD/SUB/CLEAR accumulator over a 4-bit adder-subtractor
// with valid/ready command and result ports.  Rev 1.0
// ============================================================================
`default_nettype none

module four_bit_adder_subtractor (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       m,
   output logic [3:0] Sum,
   output logic       Carry
);
   logic [3:0] bx;
   logic [4:0] c;

   assign bx   = B ^ {4{m}};
   assign c[0] = m;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign Sum[i]   = A[i] ^ bx[i] ^ c[i];
      assign c[i+1]   = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
   end

   assign Carry = c[4];
endmodule

module addsub_accumulator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [3:0]       cmd_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [3:0]       res_acc,
   output logic             res_carry,
   output logic             res_ovf,
   output logic             res_zero,
   output logic [CNT_W-1:0] op_count
);
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] op_q;
   logic [3:0] data_q;
   logic [3:0] acc;
   logic       carry_q, ovf_q, zero_q;
   logic [CNT_W-1:0] count_q;

   logic       sub_m;
   logic [3:0] sum;
   logic       add_carry;
   logic [3:0] acc_nxt;
   logic       carry_nxt, ovf_nxt;

   assign sub_m = (op_q == OP_SUB);

   four_bit_adder_subtractor u_addsub (
      .A     (acc),
      .B     (data_q),
      .m     (sub_m),
      .Sum   (sum),
      .Carry (add_carry)
   );

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      res_valid = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = S_EXEC;
         end
         S_EXEC: state_nxt = S_RESP;
         S_RESP: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Overflow uses the inverted operand only; the +1 of subtraction enters as carry-in.
   always_comb begin
      acc_nxt   = 4'h0;
      carry_nxt = 1'b0;
      ovf_nxt   = 1'b0;
      case (op_q)
         OP_LOAD: acc_nxt = data_q;
         OP_ADD, OP_SUB: begin
            acc_nxt   = sum;
            carry_nxt = add_carry;
            ovf_nxt   = (acc[3] == (data_q[3] ^ sub_m)) && (sum[3] != acc[3]);
         end
         OP_CLEAR: acc_nxt = 4'h0;
         default:  acc_nxt = 4'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q    <= OP_LOAD;
         data_q  <= 4'h0;
         acc     <= 4'h0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b1;
         count_q <= '0;
      end else begin
         if (state == S_IDLE && cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
         end
         if (state == S_EXEC) begin
            acc     <= acc_nxt;
            carry_q <= carry_nxt;
            ovf_q   <= ovf_nxt;
            zero_q  <= (acc_nxt == 4'h0);
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   assign res_acc   = acc;
   assign res_carry = carry_q;
   assign res_ovf   = ovf_q;
   assign res_zero  = zero_q;
   assign op_count  = count_q;
endmodule

`default_nettype wire

// File: tb/tb_addsub_accumulator.sv
// ============================================================================
// tb_addsub_accumulator: directed self-checking bench for addsub_accumulator.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_addsub_accumulator;
   localparam logic [1:0] LD  = 2'b00;
   localparam logic [1:0] ADD = 2'b01;
   localparam logic [1:0] SUB = 2'b10;
   localparam logic [1:0] CLR = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_acc;
   logic       res_carry;
   logic       res_ovf;
   logic       res_zero;
   logic [7:0] op_count;

   int tests = 0;
   int fails = 0;
   int lat;

   addsub_accumulator #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_acc   (res_acc),
      .res_carry (res_carry),
      .res_ovf   (res_ovf),
      .res_zero  (res_zero),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered at a falling edge in IDLE; returns at the falling edge where res_valid is first seen.
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] d);
      int n;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 1;
      while (!res_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      lat = n;
   endtask

   task automatic check_res(input string tag, input logic [3:0] a, input logic c,
                            input logic v, input logic z, input logic [7:0] cnt);
      check({tag, " valid"}, 32'(res_valid), 32'd1);
      check({tag, " acc"},   32'(res_acc),   32'(a));
      check({tag, " carry"}, 32'(res_carry), 32'(c));
      check({tag, " ovf"},   32'(res_ovf),   32'(v));
      check({tag, " zero"},  32'(res_zero),  32'(z));
      check({tag, " count"}, 32'(op_count),  32'(cnt));
   endtask

   initial begin
      logic [3:0] snap_acc;
      logic       seen_bad;
      logic       seen_valid;

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = LD; cmd_data = 4'h0; res_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset res_valid", 32'(res_valid), 32'd0);
      check("reset acc",       32'(res_acc),   32'd0);
      check("reset carry",     32'(res_carry), 32'd0);
      check("reset ovf",       32'(res_ovf),   32'd0);
      check("reset zero",      32'(res_zero),  32'd1);
      check("reset count",     32'(op_count),  32'd0);

      run_cmd(LD, 4'h5);
      check("load5 latency", 32'(lat), 32'd2);
      check_res("load5", 4'h5, 1'b0, 1'b0, 1'b0, 8'd1);
      @(negedge clk);
      check("post-handshake cmd_ready", 32'(cmd_ready), 32'd1);
      check("post-handshake res_valid", 32'(res_valid), 32'd0);
      run_cmd(ADD, 4'h3);
      check_res("5+3", 4'h8, 1'b0, 1'b1, 1'b0, 8'd2);
      @(negedge clk);

      run_cmd(LD, 4'h3);  @(negedge clk);
      run_cmd(SUB, 4'h5);
      check_res("3-5", 4'hE, 1'b0, 1'b0, 1'b0, 8'd4);
      @(negedge clk);

      run_cmd(LD, 4'h5);  @(negedge clk);
      run_cmd(SUB, 4'h5);
      check_res("5-5", 4'h0, 1'b1, 1'b0, 1'b1, 8'd6);
      @(negedge clk);

      run_cmd(LD, 4'hF);  @(negedge clk);
      run_cmd(ADD, 4'h1);
      check_res("F+1", 4'h0, 1'b1, 1'b0, 1'b1, 8'd8);
      @(negedge clk);

      run_cmd(LD, 4'h8);  @(negedge clk);
      run_cmd(SUB, 4'h1);
      check_res("8-1", 4'h7, 1'b1, 1'b1, 1'b0, 8'd10);
      @(negedge clk);

      run_cmd(CLR, 4'h9);
      check_res("clear", 4'h0, 1'b0, 1'b0, 1'b1, 8'd11);
      @(negedge clk);

      // Backpressure: hold the result for 4 cycles with the next command already waiting.
      run_cmd(LD, 4'h2);  @(negedge clk);
      res_ready = 1'b0;
      run_cmd(ADD, 4'h1);
      check_res("bp first", 4'h3, 1'b0, 1'b0, 1'b0, 8'd13);
      snap_acc  = res_acc;
      cmd_valid = 1'b1; cmd_op = ADD; cmd_data = 4'h1;
      seen_bad  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_acc !== snap_acc ||
             op_count !== 8'd13) seen_bad = 1'b1;
      end
      check("bp stall stable", 32'(seen_bad), 32'd0);
      res_ready = 1'b1;
      @(negedge clk);
      check("bp idle after handshake", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("bp held cmd in exec", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check_res("bp second", 4'h4, 1'b0, 1'b0, 1'b0, 8'd14);
      repeat (4) @(negedge clk);
      check("bp single execution", 32'(op_count), 32'd14);

      // Reset during EXEC of ADD 2 with acc = 4.
      check("pre-reset acc", 32'(res_acc), 32'd4);
      cmd_valid = 1'b1; cmd_op = ADD; cmd_data = 4'h2;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
      check("midrst acc",       32'(res_acc),   32'd0);
      check("midrst zero",      32'(res_zero),  32'd1);
      check("midrst count",     32'(op_count),  32'd0);
      seen_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (res_valid) seen_valid = 1'b1;
         @(negedge clk);
      end
      check("midrst no res_valid", 32'(seen_valid), 32'd0);
      check("midrst count held",   32'(op_count),   32'd0);

      // Counter wrap at 2^CNT_W.
      for (int i = 0; i < 255; i++) begin
         run_cmd(CLR, 4'h0);
         @(negedge clk);
      end
      check("count 255", 32'(op_count), 32'd255);
      run_cmd(ADD, 4'h6);
      check_res("count wrap", 4'h6, 1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire
